rr_mux_arbiter: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. Each cycle it arbitrates among requesting input channels and loads the winner into a single-entry output register. Arbitration is round-robin or fixed-priority, selected by parameter. It replaces hand-selected 2:1 muxes wherever several producers share one datapath to a single consumer.

---
 rtl/rr_mux_arbiter.sv | 111 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel registered multiplexer with valid/ready handshakes.
// Each cycle one requesting channel is picked, either round-robin or by fixed
// priority, and its word is loaded into a single-entry output register.
// A drain and a load in the same cycle keep the register full, so the block
// sustains one word per cycle.

module rr_mux_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RR       = 1,
    localparam int unsigned CW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [CW-1:0] LastReset = CW'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_chan_q;
    logic             out_valid_q;
    // Channel granted most recently; the search starts one past it.
    logic [CW-1:0]    last_q;

    logic             can_load;
    logic             grant_found;
    logic [CW-1:0]    grant;
    logic             xfer;

    // Unpacked view of the packed input bus, one entry per channel.
    logic [WIDTH-1:0] chan_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign can_load = !out_valid_q || out_ready;

    // Pick the winning channel among the current requesters.
    always_comb begin
        logic [CW-1:0] cand;
        int unsigned   sum;
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        sum         = 0;
        if (RR != 0) begin
            // Search last+1, last+2, ... wrapping modulo CHANNELS so the
            // index never leaves 0..CHANNELS-1, even for non-power-of-2 sizes.
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                sum  = 32'(last_q) + k;
                cand = CW'(sum % CHANNELS);
                if (!grant_found && in_valid[cand]) begin
                    grant       = cand;
                    grant_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (!grant_found && in_valid[k]) begin
                    grant       = CW'(k);
                    grant_found = 1'b1;
                end
            end
        end
    end

    // Acknowledge only the winner, and only when the output register can take it.
    always_comb begin
        in_ready = '0;
        if (can_load && grant_found) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = can_load && grant_found;

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= LastReset;
        end else begin
            if (xfer) begin
                // A load wins over a simultaneous drain: new word replaces old.
                out_data_q  <= chan_data[grant];
                out_chan_q  <= grant;
                out_valid_q <= 1'b1;
                if (RR != 0) begin
                    last_q <= grant;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus.

module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  rr_in_ready;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_chan;
    logic        rr_out_valid;

    logic [3:0]  fp_in_ready;
    logic [7:0]  fp_out_data;
    logic [1:0]  fp_out_chan;
    logic        fp_out_valid;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .RR(1)) u_rr (
        .clk       (clk),
        .rst_      (rst_),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rr_in_ready),
        .out_data  (rr_out_data),
        .out_chan  (rr_out_chan),
        .out_valid (rr_out_valid),
        .out_ready (out_ready)
    );

    rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .RR(0)) u_fp (
        .clk       (clk),
        .rst_      (rst_),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_chan  (fp_out_chan),
        .out_valid (fp_out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] eir;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Round-robin vectors, channel i data = 8'h10 + i, pointer starts at 3.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
        tbl[9]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        tbl[11] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};

        rst_      = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;

        // Reset then idle.
        tick();
        tick();
        rst_ = 1'b1;
        tick();
        chk("rst_rr_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_rr_data",  32'(rr_out_data),  32'h00);
        chk("rst_rr_chan",  32'(rr_out_chan),  32'd0);
        chk("rst_rr_ready", 32'(rr_in_ready),  32'b0000);
        chk("rst_fp_valid", 32'(fp_out_valid), 32'd0);
        chk("rst_fp_ready", 32'(fp_in_ready),  32'b0000);

        // Round-robin table.
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 15; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #2;
            chk($sformatf("tbl%0d_ready", i), 32'(rr_in_ready), 32'(tbl[i].eir));
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(rr_out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  32'(rr_out_data),  32'(tbl[i].ed));
            chk($sformatf("tbl%0d_chan", i),  32'(rr_out_chan),  32'(tbl[i].ec));
        end

        // Single channel: ch2 carries 8'hA5.
        in_data[16 +: 8] = 8'hA5;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #2;
        chk("single_ready", 32'(rr_in_ready), 32'b0100);
        tick();
        chk("single_data",  32'(rr_out_data),  32'hA5);
        chk("single_chan",  32'(rr_out_chan),  32'd2);
        chk("single_valid", 32'(rr_out_valid), 32'd1);
        in_valid = 4'b0000;
        tick();
        chk("single_drain", 32'(rr_out_valid), 32'd0);

        // Backpressure: hold 8'h3C from ch0 while ch1 waits.
        in_data[0 +: 8] = 8'h3C;
        in_data[8 +: 8] = 8'h5A;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        chk("bp_load_data", 32'(rr_out_data), 32'h3C);
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("bp%0d_ready", i), 32'(rr_in_ready), 32'b0000);
            tick();
            chk($sformatf("bp%0d_data", i),  32'(rr_out_data),  32'h3C);
            chk($sformatf("bp%0d_chan", i),  32'(rr_out_chan),  32'd0);
            chk($sformatf("bp%0d_valid", i), 32'(rr_out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #2;
        chk("bp_release_ready", 32'(rr_in_ready), 32'b0010);
        tick();
        chk("bp_swap_data",  32'(rr_out_data),  32'h5A);
        chk("bp_swap_chan",  32'(rr_out_chan),  32'd1);
        chk("bp_swap_valid", 32'(rr_out_valid), 32'd1);
        in_valid = 4'b0000;
        tick();

        // Reset mid-stream while holding a word from ch2.
        in_data[16 +: 8] = 8'h77;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        tick();
        chk("mid_pre_chan",  32'(rr_out_chan),  32'd2);
        chk("mid_pre_valid", 32'(rr_out_valid), 32'd1);
        in_valid = 4'b0000;
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid_async_valid", 32'(rr_out_valid), 32'd0);
        chk("mid_async_chan",  32'(rr_out_chan),  32'd0);
        chk("mid_async_data",  32'(rr_out_data),  32'h00);
        tick();
        tick();
        rst_      = 1'b1;
        in_valid  = 4'b1100;
        out_ready = 1'b1;
        #2;
        chk("mid_after_ready", 32'(rr_in_ready), 32'b0100);
        tick();
        chk("mid_after_chan", 32'(rr_out_chan), 32'd2);
        chk("mid_after_data", 32'(rr_out_data), 32'h77);

        // Fixed priority: ch1 always beats ch3 until ch1 drops.
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("fp%0d_ready", i), 32'(fp_in_ready), 32'b0010);
            tick();
            chk($sformatf("fp%0d_chan", i), 32'(fp_out_chan), 32'd1);
        end
        in_valid = 4'b1000;
        #2;
        chk("fp_drop_ready", 32'(fp_in_ready), 32'b1000);
        tick();
        chk("fp_drop_chan", 32'(fp_out_chan), 32'd3);
        chk("fp_drop_data", 32'(fp_out_data), 32'h13);
        in_valid = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
